// File: rtl/rns_789_to_binary.sv
// Purpose: residue-to-binary converter for moduli {7,8,9} via mixed-radix conversion (X = d0 + 8*d1 + 56*d2).
// Latency: result valid 4 cycles after the accept cycle; one conversion in flight, 5-cycle throughput.
// Backpressure: in_ready only in IDLE; result held stable in OUT until out_ready.
module rns_789_to_binary #(
    parameter bit CHECK_INVALID = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] r7,
    input  logic [2:0] r8,
    input  logic [3:0] r9,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [8:0] x_out,
    output logic       err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_D1,
        S_D2,
        S_SUM,
        S_OUT
    } state_t;

    state_t     state;
    logic [2:0] r7_q;
    logic [2:0] r8_q;   // also d0
    logic [3:0] r9_q;
    logic       bad_q;
    logic [2:0] d1_q;
    logic [3:0] d2_q;

    // Reduce a value in 0..44 modulo 9 using compare/subtract only.
    function automatic logic [3:0] mod9(input logic [5:0] v);
        logic [5:0] r;
        if (v >= 6'd36)      r = v - 6'd36;
        else if (v >= 6'd27) r = v - 6'd27;
        else if (v >= 6'd18) r = v - 6'd18;
        else if (v >= 6'd9)  r = v - 6'd9;
        else                 r = v;
        return r[3:0];
    endfunction

    logic       in_bad;
    logic [3:0] t7;
    logic [3:0] t7_red;
    logic [2:0] d1_next;
    logic [3:0] e9;
    logic [5:0] u9;
    logic [3:0] w9;
    logic [5:0] w9_x5;
    logic [3:0] d2_next;
    logic [8:0] sum9;

    // Input range check and the mixed-radix digit arithmetic.
    always_comb begin
        in_bad  = CHECK_INVALID && ((r7 == 3'd7) || (r9 > 4'd8));

        // d1 = (r7 - d0) mod 7; biased by +7 so the difference stays non-negative (0..14).
        t7      = {1'b0, r7_q} + 4'd7 - {1'b0, r8_q};
        if (t7 >= 4'd14)     t7_red = t7 - 4'd14;
        else if (t7 >= 4'd7) t7_red = t7 - 4'd7;
        else                 t7_red = t7;
        d1_next = t7_red[2:0];

        // 8*d1 mod 9 equals (9 - d1) mod 9.
        e9      = (d1_q == 3'd0) ? 4'd0 : (4'd9 - {1'b0, d1_q});
        // (r9 - d0 - 8*d1) mod 9, biased by +18 to stay non-negative (3..33).
        u9      = {2'b00, r9_q} + 6'd18 - {3'b000, r8_q} - {2'b00, e9};
        w9      = mod9(u9);
        // d2 = 5*w mod 9, with 5*w built as 4*w + w.
        w9_x5   = {w9, 2'b00} + {2'b00, w9};
        d2_next = mod9(w9_x5);

        // 56*d2 = 64*d2 - 8*d2; 9-bit wraparound is exact since the true sum is at most 503.
        sum9    = {6'd0, r8_q} + {3'd0, d1_q, 3'b000}
                + {d2_q[2:0], 6'd0} - {2'b00, d2_q, 3'b000};
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            x_out     <= 9'd0;
            err       <= 1'b0;
            r7_q      <= 3'd0;
            r8_q      <= 3'd0;
            r9_q      <= 4'd0;
            bad_q     <= 1'b0;
            d1_q      <= 3'd0;
            d2_q      <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        r7_q     <= r7;
                        r8_q     <= r8;
                        r9_q     <= r9;
                        bad_q    <= in_bad;
                        in_ready <= 1'b0;
                        state    <= S_D1;
                    end
                end
                S_D1: begin
                    d1_q  <= d1_next;
                    state <= S_D2;
                end
                S_D2: begin
                    d2_q  <= d2_next;
                    state <= S_SUM;
                end
                S_SUM: begin
                    x_out     <= bad_q ? 9'd0 : sum9;
                    err       <= bad_q;
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rns_789_to_binary.sv
// Purpose: self-checking bench for rns_789_to_binary using a vector table, a sweep and corner sequences.
// Latency: expects out_valid 4 cycles after the accept cycle and 5-cycle spacing back-to-back.
// Backpressure: exercises held out_ready, result stability and reset while a conversion is in flight.
module tb_rns_789_to_binary;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] r7;
    logic [2:0] r8;
    logic [3:0] r9;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] x_out;
    logic       err;

    rns_789_to_binary #(.CHECK_INVALID(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r7        (r7),
        .r8        (r8),
        .r9        (r9),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x_out     (x_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] r7;
        logic [2:0] r8;
        logic [3:0] r9;
        logic [8:0] x;
        logic       e;
    } vec_t;

    typedef struct {
        logic [8:0] x;
        logic       e;
    } exp_t;

    exp_t       q[$];
    logic [8:0] exp_x_next = 9'd0;
    logic       exp_e_next = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    // monitor state
    bit         sweep = 1'b0;
    int         sweep_acc = 0;
    int         last_acc = 0;
    bit         have_acc = 1'b0;
    bit         prev_ov = 1'b0;
    logic [8:0] prev_x = 9'd0;
    logic       prev_e = 1'b0;

    task automatic chk(input bit ok, input string name, input int act, input int req);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard and protocol checks, sampled on the falling edge.
    task automatic mon_step();
        exp_t e;
        if (rst) begin
            q.delete();
            have_acc  = 1'b0;
            prev_ov   = 1'b0;
            sweep_acc = 0;
            return;
        end
        if (have_acc && (cyc - last_acc) >= 1 && (cyc - last_acc) <= 3) begin
            chk(in_ready == 1'b0, "in_ready_busy", int'(in_ready), 0);
            chk(out_valid == 1'b0, "out_valid_early", int'(out_valid), 0);
        end
        if (out_valid && !prev_ov) begin
            if (have_acc) chk((cyc - last_acc) == 4, "latency", cyc - last_acc, 4);
            else          chk(1'b0, "out_valid_without_input", 1, 0);
        end
        if (out_valid) chk(in_ready == 1'b0, "in_ready_in_out", int'(in_ready), 0);
        if (out_valid && prev_ov) begin
            chk(x_out == prev_x, "x_out_stable", int'(x_out), int'(prev_x));
            chk(err == prev_e, "err_stable", int'(err), int'(prev_e));
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk(1'b0, "unexpected_result", int'(x_out), -1);
            end else begin
                e = q.pop_front();
                chk(x_out == e.x, "x_out", int'(x_out), int'(e.x));
                chk(err == e.e, "err", int'(err), int'(e.e));
            end
        end
        if (!sweep) sweep_acc = 0;
        if (in_valid && in_ready) begin
            q.push_back('{x: exp_x_next, e: exp_e_next});
            if (sweep && sweep_acc > 0) chk((cyc - last_acc) == 5, "spacing", cyc - last_acc, 5);
            if (sweep) sweep_acc++;
            last_acc = cyc;
            have_acc = 1'b1;
        end
        prev_ov = out_valid;
        prev_x  = x_out;
        prev_e  = err;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one triple and hold it until accepted; returns just after the accept edge.
    task automatic send(input logic [2:0] a, input logic [2:0] b, input logic [3:0] c,
                        input logic [8:0] ex, input logic ee);
        bit got;
        got        = 1'b0;
        r7         = a;
        r8         = b;
        r9         = c;
        exp_x_next = ex;
        exp_e_next = ee;
        in_valid   = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1'b1;
            step();
        end
        in_valid = 1'b0;
        if (!got) chk(1'b0, "accept_timeout", 0, 1);
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (q.size() == 0 && !out_valid) done = 1'b1;
            else step();
        end
        if (!done) chk(1'b0, "drain_timeout", q.size(), 0);
    endtask

    vec_t tbl[9];

    initial begin
        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
        join_none

        tbl[0] = '{r7: 3'd2, r8: 3'd4, r9: 4'd1, x: 9'd100, e: 1'b0};
        tbl[1] = '{r7: 3'd0, r8: 3'd0, r9: 4'd0, x: 9'd0,   e: 1'b0};
        tbl[2] = '{r7: 3'd6, r8: 3'd7, r9: 4'd8, x: 9'd503, e: 1'b0};
        tbl[3] = '{r7: 3'd3, r8: 3'd7, r9: 4'd3, x: 9'd255, e: 1'b0};
        tbl[4] = '{r7: 3'd1, r8: 3'd1, r9: 4'd1, x: 9'd1,   e: 1'b0};
        tbl[5] = '{r7: 3'd7, r8: 3'd0, r9: 4'd0, x: 9'd0,   e: 1'b1};
        tbl[6] = '{r7: 3'd2, r8: 3'd4, r9: 4'd1, x: 9'd100, e: 1'b0};
        tbl[7] = '{r7: 3'd0, r8: 3'd0, r9: 4'd9, x: 9'd0,   e: 1'b1};
        tbl[8] = '{r7: 3'd6, r8: 3'd7, r9: 4'd15, x: 9'd0,  e: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        r7        = 3'd0;
        r8        = 3'd0;
        r9        = 4'd0;

        // Reset state
        step();
        step();
        chk(in_ready == 1'b0, "rst_in_ready", int'(in_ready), 0);
        chk(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
        chk(x_out == 9'd0, "rst_x_out", int'(x_out), 0);
        chk(err == 1'b0, "rst_err", int'(err), 0);
        rst = 1'b0;
        step();
        chk(in_ready == 1'b1, "in_ready_after_rst", int'(in_ready), 1);

        // Table of known vectors, one at a time
        foreach (tbl[i]) begin
            send(tbl[i].r7, tbl[i].r8, tbl[i].r9, tbl[i].x, tbl[i].e);
            drain();
        end

        // Back-to-back sweep of the full dynamic range
        sweep = 1'b1;
        for (int x = 0; x < 504; x++) begin
            send(3'(x % 7), 3'(x % 8), 4'(x % 9), 9'(x), 1'b0);
        end
        drain();
        sweep = 1'b0;
        step();

        // Backpressure on the 503 result
        out_ready = 1'b0;
        send(3'd6, 3'd7, 4'd8, 9'd503, 1'b0);
        for (int i = 0; i < 20 && !out_valid; i++) step();
        chk(out_valid == 1'b1, "bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk(out_valid == 1'b1 && x_out == 9'd503, "bp_hold_x", int'(x_out), 503);
            chk(in_ready == 1'b0, "bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk(out_valid == 1'b0, "bp_release_out_valid", int'(out_valid), 0);
        chk(in_ready == 1'b1, "bp_release_in_ready", int'(in_ready), 1);
        chk(q.size() == 0, "bp_popped", q.size(), 0);

        // Reset while in D2 discards the conversion
        send(3'd5, 3'd5, 4'd5, 9'd5, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
        chk(x_out == 9'd0, "midrst_x_out", int'(x_out), 0);
        chk(in_ready == 1'b0, "midrst_in_ready", int'(in_ready), 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk(out_valid == 1'b0, "midrst_no_result", int'(out_valid), 0);
        end
        send(3'd2, 3'd4, 4'd1, 9'd100, 1'b0);
        drain();
        chk(q.size() == 0, "final_queue_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
